// File: rtl/screen_frame_writer.sv
// screen_frame_writer: double-buffered 16x8 LED frame producer.
// Clients edit a back buffer; a commit copies it to the front on frame_tick.
module screen_frame_writer #(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int DW   = ROWS * COLS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [RW-1:0] wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic [COLS-1:0] wr_mask,
    input  logic          clear,
    input  logic          commit,
    input  logic          frame_tick,
    output logic          commit_pend,
    output logic          swap_done,
    output logic [DW-1:0] data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_rdy_en;
    logic            r_commit_pend;
    logic            r_swap_done;
    logic [DW-1:0]   r_front;
    logic [COLS-1:0] r_back [ROWS];

    logic            w_acc;
    logic            w_clr;
    logic [COLS-1:0] w_back_nxt [ROWS];
    logic [DW-1:0]   w_back_flat;

    assign wr_ready    = r_rdy_en & ~r_commit_pend;
    assign commit_pend = r_commit_pend;
    assign swap_done   = r_swap_done;
    assign data        = r_front;

    assign w_acc = wr_valid & wr_ready;
    assign w_clr = clear & ~r_commit_pend;

    // Next back-buffer contents: clear first, then the masked row write on top.
    // Rows outside 0..ROWS-1 match no entry, so such writes are accepted and dropped.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_back_nxt[r] = w_clr ? '0 : r_back[r];
            if (w_acc && (wr_row == RW'(r))) begin
                w_back_nxt[r] = (w_back_nxt[r] & ~wr_mask) |
                                (wr_data & wr_mask);
            end
        end
    end

    // Pack the back rows with row 0 in the top bits, the order the scanner reads.
    always_comb begin
        w_back_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_back_flat[DW-1-COLS*r -: COLS] = r_back[r];
        end
    end

    // Back buffer storage; frozen while a commit is pending since no write or clear acts then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_back[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                r_back[r] <= w_back_nxt[r];
            end
        end
    end

    // Write port opens on the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Commit FSM: latch a request, then swap back into front on the next frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_commit_pend <= 1'b0;
            r_swap_done   <= 1'b0;
            r_front       <= '0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (commit) begin
                        r_state       <= S_PEND;
                        r_commit_pend <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (frame_tick) begin
                        r_front       <= w_back_flat;
                        r_state       <= S_IDLE;
                        r_commit_pend <= 1'b0;
                        r_swap_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_commit_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_frame_writer.sv
// tb_screen_frame_writer: directed scenarios plus random traffic
// checked against a row-array model of the two frame buffers.
module tb_screen_frame_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_row;
    logic [15:0]  wr_data;
    logic [15:0]  wr_mask;
    logic         clear;
    logic         commit;
    logic         frame_tick;
    logic         commit_pend;
    logic         swap_done;
    logic [127:0] data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_back  [8];
    logic [15:0] m_front [8];
    logic        m_pend;
    logic        m_swap;
    logic        m_rdy;

    screen_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .clear      (clear),
        .commit     (commit),
        .frame_tick (frame_tick),
        .commit_pend(commit_pend),
        .swap_done  (swap_done),
        .data       (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] m_data();
        logic [127:0] f;
        for (int r = 0; r < 8; r++) begin
            f[127-16*r -: 16] = m_front[r];
        end
        return f;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, "_data"}, data, m_data());
        chk({tag, "_pend"}, 128'(commit_pend), 128'(m_pend));
        chk({tag, "_swap"}, 128'(swap_done), 128'(m_swap));
        chk({tag, "_rdy"}, 128'(wr_ready), 128'(m_rdy && !m_pend));
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_back[r]  = '0;
            m_front[r] = '0;
        end
        m_pend = 1'b0;
        m_swap = 1'b0;
        m_rdy  = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_valid   = 1'b0;
        wr_row     = '0;
        wr_data    = '0;
        wr_mask    = '0;
        clear      = 1'b0;
        commit     = 1'b0;
        frame_tick = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, check at the next negedge.
    task automatic step(input string tag, input logic v, input logic [2:0] row,
                        input logic [15:0] d, input logic [15:0] m,
                        input logic clr, input logic cm, input logic tk,
                        output logic acc);
        logic [15:0] nb [8];
        wr_valid   = v;
        wr_row     = row;
        wr_data    = d;
        wr_mask    = m;
        clear      = clr;
        commit     = cm;
        frame_tick = tk;
        acc = v && m_rdy && !m_pend;
        for (int r = 0; r < 8; r++) begin
            nb[r] = (clr && !m_pend) ? 16'h0 : m_back[r];
        end
        if (acc) begin
            nb[row] = (nb[row] & ~m) | (d & m);
        end
        m_swap = m_pend && tk;
        if (m_swap) begin
            for (int r = 0; r < 8; r++) begin
                m_front[r] = m_back[r];
            end
        end
        m_pend = m_pend ? !tk : cm;
        for (int r = 0; r < 8; r++) begin
            m_back[r] = nb[r];
        end
        m_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("rst_hold");
        rst = 1'b0;
        #1;
        chk("rst_rdy_pre", 128'(wr_ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
        m_rdy = 1'b1;
        chk_all("rst_rel");
        chk("rst_rdy_post", 128'(wr_ready), 128'(1));
    endtask

    logic        a;
    logic        hold;
    logic        rv, rc, rk, rcl;
    logic [2:0]  rr;
    logic [15:0] rd, rm;

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();

        do_reset();

        step("t2_wr", 1, 3'd0, 16'hFFFF, 16'hFFFF, 0, 0, 0, a);
        step("t2_cm", 0, 0, 0, 0, 0, 1, 0, a);
        repeat (4) step("t2_wait", 0, 0, 0, 0, 0, 0, 0, a);
        step("t2_tk", 0, 0, 0, 0, 0, 0, 1, a);
        chk("t2_row0", 128'(data[127:112]), 128'(16'hFFFF));
        chk("t2_rest", 128'(data[111:0]), 128'(0));
        chk("t2_swap1", 128'(swap_done), 128'(1));
        step("t2_after", 0, 0, 0, 0, 0, 0, 0, a);
        chk("t2_swap0", 128'(swap_done), 128'(0));

        step("t3_w1", 1, 3'd3, 16'hAAAA, 16'hFFFF, 0, 0, 0, a);
        step("t3_w2", 1, 3'd3, 16'h0000, 16'h00FF, 0, 0, 0, a);
        step("t3_cm", 0, 0, 0, 0, 0, 1, 0, a);
        step("t3_tk", 0, 0, 0, 0, 0, 0, 1, a);
        chk("t3_row3", 128'(data[79:64]), 128'(16'hAA00));

        step("t4_cm", 0, 0, 0, 0, 0, 1, 0, a);
        repeat (3) begin
            step("t4_stall", 1, 3'd5, 16'h1234, 16'hFFFF, 0, 0, 0, a);
            chk("t4_acc", 128'(a), 128'(0));
        end
        chk("t4_hold", 128'(data[47:32]), 128'(0));
        step("t4_tk", 1, 3'd5, 16'h1234, 16'hFFFF, 0, 0, 1, a);
        chk("t4_acc_tk", 128'(a), 128'(0));
        step("t4_land", 1, 3'd5, 16'h1234, 16'hFFFF, 0, 0, 0, a);
        chk("t4_acc_go", 128'(a), 128'(1));
        step("t4_cm2", 0, 0, 0, 0, 0, 1, 0, a);
        step("t4_tk2", 0, 0, 0, 0, 0, 0, 1, a);
        chk("t4_row5", 128'(data[47:32]), 128'(16'h1234));

        step("t5_clrw", 1, 3'd2, 16'h0001, 16'hFFFF, 1, 0, 0, a);
        step("t5_cm", 0, 0, 0, 0, 0, 1, 0, a);
        step("t5_tk", 0, 0, 0, 0, 0, 0, 1, a);
        chk("t5_frame", data, 128'h0000_0000_0001_0000_0000_0000_0000_0000);

        step("t6_w", 1, 3'd7, 16'hBEEF, 16'hFFFF, 0, 0, 0, a);
        step("t6_both", 0, 0, 0, 0, 0, 1, 1, a);
        chk("t6_noswap", 128'(data[15:0]), 128'(0));
        step("t6_tk", 0, 0, 0, 0, 0, 0, 1, a);
        chk("t6_row7", 128'(data[15:0]), 128'(16'hBEEF));
        step("t6_w2", 1, 3'd1, 16'h5555, 16'hFFFF, 0, 0, 0, a);
        step("t6_cm", 0, 0, 0, 0, 0, 1, 0, a);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_data", data, 128'(0));
        chk("t6_rst_pend", 128'(commit_pend), 128'(0));
        chk("t6_rst_rdy", 128'(wr_ready), 128'(0));
        do_reset();

        hold = 1'b0;
        rv = 0; rr = 0; rd = 0; rm = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                rv = ($urandom_range(0, 2) != 0);
                rr = 3'($urandom_range(0, 7));
                rd = 16'($urandom);
                rm = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            end
            rcl = ($urandom_range(0, 19) == 0);
            rc  = ($urandom_range(0, 7) == 0);
            rk  = ($urandom_range(0, 5) == 0);
            step("rnd", rv, rr, rd, rm, rcl, rc, rk, a);
            hold = rv && !a;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
